// File: rtl/tl_c_channel_arbiter.sv
// TileLink C-channel arbiter: probe unit vs writeback unit, burst-locked grant, one Release in flight.
// Optional TL_C_ARB_RR_EN: round-robin between eligible requesters in IDLE (default: probe-first).
module tl_c_channel_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned SOURCE_W    = 4,
  parameter int unsigned SIZE_W      = 4,
  parameter int unsigned DATA_W      = 128,
  parameter int unsigned BLOCK_BYTES = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                prb_valid,
  output logic                prb_ready,
  input  logic [2:0]          prb_opcode,
  input  logic [2:0]          prb_param,
  input  logic [SIZE_W-1:0]   prb_size,
  input  logic [SOURCE_W-1:0] prb_source,
  input  logic [ADDR_W-1:0]   prb_address,
  input  logic [DATA_W-1:0]   prb_data,
  input  logic                wb_valid,
  output logic                wb_ready,
  input  logic [2:0]          wb_opcode,
  input  logic [2:0]          wb_param,
  input  logic [SIZE_W-1:0]   wb_size,
  input  logic [SOURCE_W-1:0] wb_source,
  input  logic [ADDR_W-1:0]   wb_address,
  input  logic [DATA_W-1:0]   wb_data,
  output logic                c_valid,
  input  logic                c_ready,
  output logic [2:0]          c_opcode,
  output logic [2:0]          c_param,
  output logic [SIZE_W-1:0]   c_size,
  output logic [SOURCE_W-1:0] c_source,
  output logic [ADDR_W-1:0]   c_address,
  output logic [DATA_W-1:0]   c_data,
  output logic                c_corrupt,
  input  logic                d_valid,
  input  logic                d_ready,
  input  logic [2:0]          d_opcode,
  output logic                release_busy
);

  localparam int unsigned BEAT_BYTES = DATA_W / 8;
  localparam int unsigned MAX_BEATS  = BLOCK_BYTES / BEAT_BYTES;
  localparam int unsigned LG_BEAT    = $clog2(BEAT_BYTES);
  localparam int unsigned LG_MAX     = $clog2(MAX_BEATS);
  localparam int unsigned CNT_W      = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  typedef enum logic [1:0] {IDLE, BURST_PRB, BURST_WB} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               rel_pend, rel_pend_nxt;
  logic               sel_prb, sel_wb;
  logic               wb_elig, fire, rel_set, d_ack;
  logic [CNT_W-1:0]   cur_m1;
`ifdef TL_C_ARB_RR_EN
  logic               rr_wb, rr_wb_nxt, last;
`endif

  // Beats remaining after the first: 0 for dataless or sub-beat messages, clamped to a block.
  function automatic logic [CNT_W-1:0] beats_m1(input logic [2:0] op, input logic [SIZE_W-1:0] sz);
    if (!op[0] || 32'(sz) <= LG_BEAT) return '0;
    if (32'(sz) - LG_BEAT >= LG_MAX) return CNT_W'(MAX_BEATS - 1);
    return CNT_W'((32'd1 << (32'(sz) - LG_BEAT)) - 32'd1);
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      rel_pend <= 1'b0;
`ifdef TL_C_ARB_RR_EN
      rr_wb    <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      rel_pend <= rel_pend_nxt;
`ifdef TL_C_ARB_RR_EN
      rr_wb    <= rr_wb_nxt;
`endif
    end
  end

  assign wb_elig = wb_valid && !rel_pend;

  // Grant select: combinational pick in IDLE, locked owner during a burst, nothing in reset.
  always_comb begin
    sel_prb = 1'b0;
    sel_wb  = 1'b0;
    case (state)
      IDLE: begin
`ifdef TL_C_ARB_RR_EN
        if (prb_valid && wb_elig) begin
          sel_wb  = rr_wb;
          sel_prb = !rr_wb;
        end else begin
          sel_prb = prb_valid;
          sel_wb  = wb_elig;
        end
`else
        sel_prb = prb_valid;
        sel_wb  = !prb_valid && wb_elig;
`endif
      end
      BURST_PRB: sel_prb = 1'b1;
      BURST_WB:  sel_wb  = 1'b1;
      default: ;
    endcase
    if (reset) begin
      sel_prb = 1'b0;
      sel_wb  = 1'b0;
    end
  end

  assign c_valid   = (sel_prb && prb_valid) || (sel_wb && wb_valid);
  assign prb_ready = sel_prb && c_ready;
  assign wb_ready  = sel_wb && c_ready;
  assign c_opcode  = sel_wb ? wb_opcode  : prb_opcode;
  assign c_param   = sel_wb ? wb_param   : prb_param;
  assign c_size    = sel_wb ? wb_size    : prb_size;
  assign c_source  = sel_wb ? wb_source  : prb_source;
  assign c_address = sel_wb ? wb_address : prb_address;
  assign c_data    = sel_wb ? wb_data    : prb_data;
  assign c_corrupt = 1'b0;
  assign release_busy = rel_pend;

  assign fire    = c_valid && c_ready;
  assign cur_m1  = beats_m1(c_opcode, c_size);
  assign rel_set = fire && sel_wb && (state == IDLE) && (c_opcode[2:1] == 2'b11);
  assign d_ack   = d_valid && d_ready && (d_opcode == 3'd6);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    rel_pend_nxt = rel_set ? 1'b1 : (d_ack ? 1'b0 : rel_pend);
    case (state)
      IDLE: begin
        if (fire && cur_m1 != '0) begin
          state_nxt = sel_wb ? BURST_WB : BURST_PRB;
          cnt_nxt   = cur_m1;
        end
      end
      BURST_PRB, BURST_WB: begin
        if (fire) begin
          cnt_nxt = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef TL_C_ARB_RR_EN
  // After a completed message, favour the requester that was not just served.
  assign last = fire && ((state == IDLE) ? (cur_m1 == '0) : (cnt == CNT_W'(1)));
  always_comb begin
    rr_wb_nxt = rr_wb;
    if (last) rr_wb_nxt = sel_prb;
  end
`endif

endmodule

// File: tb/tb_tl_c_channel_arbiter.sv
// Randomized scoreboard bench for tl_c_channel_arbiter against a message-level reference model.
module tb_tl_c_channel_arbiter;

  localparam int NCYC = 4000;

  logic         clock = 1'b0;
  logic         reset;
  logic         prb_valid, prb_ready, wb_valid, wb_ready;
  logic [2:0]   prb_opcode, prb_param, wb_opcode, wb_param;
  logic [3:0]   prb_size, prb_source, wb_size, wb_source;
  logic [31:0]  prb_address, wb_address;
  logic [127:0] prb_data, wb_data;
  logic         c_valid, c_ready, c_corrupt;
  logic [2:0]   c_opcode, c_param;
  logic [3:0]   c_size, c_source;
  logic [31:0]  c_address;
  logic [127:0] c_data;
  logic         d_valid, d_ready;
  logic [2:0]   d_opcode;
  logic         release_busy;

  tl_c_channel_arbiter dut (
    .clock(clock), .reset(reset),
    .prb_valid(prb_valid), .prb_ready(prb_ready), .prb_opcode(prb_opcode), .prb_param(prb_param),
    .prb_size(prb_size), .prb_source(prb_source), .prb_address(prb_address), .prb_data(prb_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_opcode(wb_opcode), .wb_param(wb_param),
    .wb_size(wb_size), .wb_source(wb_source), .wb_address(wb_address), .wb_data(wb_data),
    .c_valid(c_valid), .c_ready(c_ready), .c_opcode(c_opcode), .c_param(c_param), .c_size(c_size),
    .c_source(c_source), .c_address(c_address), .c_data(c_data), .c_corrupt(c_corrupt),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .release_busy(release_busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]   op;
    logic [2:0]   param;
    logic [3:0]   size;
    logic [3:0]   src;
    logic [31:0]  addr;
    logic [127:0] base;
    int           beats;
    int           idx;
  } msg_t;

  typedef struct {
    bit           in_reset;
    bit           cv;
    bit           pr;
    bit           wr;
    bit           rb;
    logic [174:0] fields;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  function automatic int beats_of(logic [2:0] op, logic [3:0] size);
    int n;
    if (!op[0]) return 1;
    n = (1 << size) / 16;
    if (n < 1) n = 1;
    if (n > 4) n = 4;
    return n;
  endfunction

  function automatic msg_t new_msg(bit is_wb);
    msg_t m;
    m.op    = is_wb ? 3'(6 + $urandom_range(0, 1)) : 3'(4 + $urandom_range(0, 1));
    m.param = 3'($urandom_range(0, 5));
    m.size  = 4'($urandom_range(3, 6));
    m.src   = 4'($urandom);
    m.addr  = $urandom;
    m.base  = {$urandom, $urandom, $urandom, $urandom};
    m.beats = beats_of(m.op, m.size);
    m.idx   = 0;
    return m;
  endfunction

  function automatic logic [174:0] fields_of(msg_t m);
    return {m.op, m.param, m.size, m.src, m.addr, m.base + 128'(m.idx)};
  endfunction

  task automatic chk(string name, logic [174:0] act, logic [174:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per cycle and compares it with what the DUT presents.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("c_valid", 175'(c_valid), 175'(e.cv));
        chk("prb_ready", 175'(prb_ready), 175'(e.pr));
        chk("wb_ready", 175'(wb_ready), 175'(e.wr));
        if (!e.in_reset) begin
          chk("release_busy", 175'(release_busy), 175'(e.rb));
          chk("c_corrupt", 175'(c_corrupt), 175'(0));
        end
        if (e.cv)
          chk("c_fields", {c_opcode, c_param, c_size, c_source, c_address, c_data}, e.fields);
      end
    end
  end

  // Stimulus plus reference model: grant follows message ownership, pending Release and priority.
  initial begin
    msg_t pm, wm, m;
    exp_t e;
    bit   rst, pr, wr, fire, ack, set;
    int   g;
    bit   pend = 1'b0;
`ifdef TL_C_ARB_RR_EN
    bit   rr_wb = 1'b0;
`endif
    pm = new_msg(1'b0);
    wm = new_msg(1'b1);
    reset = 1'b1; prb_valid = 1'b0; wb_valid = 1'b0; c_ready = 1'b0;
    d_valid = 1'b0; d_ready = 1'b0; d_opcode = 3'd0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clock);
      rst = (cyc < 3) || ($urandom_range(0, 299) == 0);
      reset     = rst;
      prb_valid = ($urandom_range(0, 3) != 0) && (cyc % 500 < 400);
      wb_valid  = ($urandom_range(0, 3) != 0);
      c_ready   = ($urandom_range(0, 3) != 0);
      d_valid   = $urandom_range(0, 1) == 1;
      d_ready   = $urandom_range(0, 1) == 1;
      d_opcode  = (pend && $urandom_range(0, 3) == 0) ? 3'd6 : 3'($urandom_range(0, 7));
      {prb_opcode, prb_param, prb_size, prb_source, prb_address, prb_data} = fields_of(pm);
      {wb_opcode, wb_param, wb_size, wb_source, wb_address, wb_data} = fields_of(wm);

      g = 0;
      if (!rst) begin
        if (pm.idx > 0) g = 1;
        else if (wm.idx > 0) g = 2;
        else begin
          pr = prb_valid;
          wr = wb_valid && !pend;
          if (pr && wr) begin
`ifdef TL_C_ARB_RR_EN
            g = rr_wb ? 2 : 1;
`else
            g = 1;
`endif
          end else if (pr) g = 1;
          else if (wr) g = 2;
        end
      end
      m = (g == 2) ? wm : pm;
      e.in_reset = rst;
      e.cv = (g == 1 && prb_valid) || (g == 2 && wb_valid);
      e.pr = (g == 1) && c_ready;
      e.wr = (g == 2) && c_ready;
      e.rb = pend;
      e.fields = fields_of(m);
      q.push_back(e);
      fire = e.cv && c_ready;
      ack  = d_valid && d_ready && (d_opcode == 3'd6);

      @(posedge clock);
      if (rst) begin
        pend = 1'b0;
`ifdef TL_C_ARB_RR_EN
        rr_wb = 1'b0;
`endif
        pm = new_msg(1'b0);
        wm = new_msg(1'b1);
      end else begin
        set = fire && g == 2 && m.idx == 0 && m.op[2:1] == 2'b11;
        if (fire) begin
          m.idx++;
          if (m.idx == m.beats) begin
            m = new_msg(g == 2);
`ifdef TL_C_ARB_RR_EN
            rr_wb = (g == 1);
`endif
          end
          if (g == 2) wm = m; else pm = m;
        end
        pend = set ? 1'b1 : (ack ? 1'b0 : pend);
      end
    end
    @(negedge clock);
    reset = 1'b0; prb_valid = 1'b0; wb_valid = 1'b0;
    repeat (3) @(negedge clock);
    chk("queue_drained", 175'(q.size()), 175'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
